// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with in-order req/ack drain and youngest-match load snoop
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  input  logic [AW-1:0]                st_addr,
  input  logic [DW-1:0]                st_data,
  output logic                         st_ready,
  input  logic [AW-1:0]                ld_addr,
  output logic                         ld_hit,
  output logic [DW-1:0]                ld_data,
  output logic                         mem_req,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_wdata,
  input  logic                         mem_ack,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int WAW = AW - 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [WAW-1:0]    addr_q [DEPTH];
  logic [WAW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]     data_q [DEPTH];
  logic [DW-1:0]     data_d [DEPTH];

  logic enq;
  logic deq;
  logic unused_addr_lsbs;

  // Byte offsets never take part in matching or draining.
  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ready = (count_q < FULL_CNT);
  assign mem_req  = (state_q == BUSY);
  assign empty    = (count_q == '0) && (state_q == IDLE);
  assign count    = count_q;
  assign enq      = st_valid && st_ready;
  assign deq      = mem_req && mem_ack;

  assign mem_addr  = mem_req ? {addr_q[rd_ptr_q], 2'b00} : '0;
  assign mem_wdata = mem_req ? data_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    count_d  = count_q + CW'(enq) - CW'(deq);
    state_d  = state_q;

    if (enq) begin
      addr_d[wr_ptr_q]  = st_addr[AW-1:2];
      data_d[wr_ptr_q]  = st_data;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end

    case (state_q)
      IDLE: if (count_q != '0) state_d = BUSY;
      BUSY: if (deq && (count_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == ld_addr[AW-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer: FIFO drain order, snoop, full/ack corner, reset mid-drain
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          st_valid = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic          st_ready;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic          empty;
  logic [CW-1:0] count;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int drained  = 0;

  // Reference contents, oldest first: {word-aligned address, data}.
  logic [63:0] model_q[$];
  bit          model_req = 1'b0;
  int          m_cnt;
  bit          m_hit;
  logic [31:0] m_ld;
  logic [63:0] m_pop;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      model_q.delete();
      model_req = 1'b0;
    end else begin
      m_cnt = model_q.size();
      check("count", 64'(count), 64'(m_cnt));
      check("st_ready", 64'(st_ready), 64'(m_cnt < DEPTH));
      check("empty", 64'(empty), 64'(m_cnt == 0));
      check("mem_req", 64'(mem_req), 64'(model_req));
      m_hit = 1'b0;
      m_ld  = '0;
      foreach (model_q[i]) begin
        if (model_q[i][63:34] == ld_addr[31:2]) begin
          m_hit = 1'b1;
          m_ld  = model_q[i][31:0];
        end
      end
      check("ld_hit", 64'(ld_hit), 64'(m_hit));
      check("ld_data", 64'(ld_data), 64'(m_ld));
      if (mem_req) begin
        if (m_cnt == 0) begin
          check("mem_req_with_nothing_buffered", 64'(mem_req), 64'(0));
        end else begin
          check("mem_addr", 64'(mem_addr), 64'(model_q[0][63:32]));
          check("mem_wdata", 64'(mem_wdata), 64'(model_q[0][31:0]));
        end
      end else begin
        check("mem_addr_idle", 64'(mem_addr), 64'(0));
        check("mem_wdata_idle", 64'(mem_wdata), 64'(0));
      end
      if (mem_req && mem_ack && m_cnt > 0) begin
        m_pop = model_q.pop_front();
        drained++;
      end
      if (st_valid && m_cnt < DEPTH)
        model_q.push_back({st_addr[31:2], 2'b00, st_data});
      model_req = (m_cnt > 0) && (model_q.size() > 0);
    end
  end

  task automatic wait_empty(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (empty && count == '0) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 64'(done), 64'(1));
  endtask

  task automatic raw_store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    @(posedge clk); #1;
  endtask

  task automatic rand_store(input logic [31:0] a, input logic [31:0] d);
    bit acc;
    bit done;
    done     = 1'b0;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    for (int i = 0; i < 60; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      ld_addr = 32'h300 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      acc     = st_ready;
      @(posedge clk); #1;
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    st_valid = 1'b0;
    check("t5_store_accepted", 64'(done), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_st_ready", 64'(st_ready), 64'(1));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_ld_hit", 64'(ld_hit), 64'(0));
    check("rst_count", 64'(count), 64'(0));

    // T1: single store with ack tied high
    mem_ack = 1'b1;
    raw_store(32'h100, 32'hAAAA0001);
    st_valid = 1'b0;
    check("t1_req_after_enq", 64'(mem_req), 64'(0));
    @(posedge clk); #1;
    check("t1_req_raised", 64'(mem_req), 64'(1));
    check("t1_mem_addr", 64'(mem_addr), 64'h100);
    check("t1_mem_wdata", 64'(mem_wdata), 64'hAAAA0001);
    @(posedge clk); #1;
    check("t1_req_dropped", 64'(mem_req), 64'(0));
    check("t1_empty", 64'(empty), 64'(1));

    // T2: five stores with ack held low, then drain
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) raw_store(32'h400 + 32'(i * 4), 32'hB0 + 32'(i));
    st_valid = 1'b0;
    check("t2_count_full", 64'(count), 64'(4));
    check("t2_st_ready_full", 64'(st_ready), 64'(0));
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t2_drain_count", 64'(count), 64'(3 - i));
    end
    check("t2_drained_idle", 64'(mem_req), 64'(0));

    // T3: youngest match wins within a word
    mem_ack = 1'b0;
    raw_store(32'h200, 32'd1);
    raw_store(32'h204, 32'd2);
    raw_store(32'h202, 32'd3);
    st_valid = 1'b0;
    ld_addr  = 32'h201;
    #1;
    check("t3_hit", 64'(ld_hit), 64'(1));
    check("t3_data", 64'(ld_data), 64'(3));
    ld_addr = 32'h208;
    #1;
    check("t3_miss_hit", 64'(ld_hit), 64'(0));
    check("t3_miss_data", 64'(ld_data), 64'(0));
    mem_ack = 1'b1;
    wait_empty("t3_drain_timeout", 20);

    // T4: store and ack together while full
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) raw_store(32'h500 + 32'(i * 4), 32'hC0 + 32'(i));
    st_valid = 1'b1;
    st_addr  = 32'h600;
    st_data  = 32'hC4;
    mem_ack  = 1'b1;
    @(posedge clk); #1;
    check("t4_count_after_ack", 64'(count), 64'(3));
    check("t4_st_ready", 64'(st_ready), 64'(1));
    mem_ack = 1'b0;
    @(posedge clk); #1;
    st_valid = 1'b0;
    check("t4_count_after_store", 64'(count), 64'(4));
    mem_ack = 1'b1;
    wait_empty("t4_drain_timeout", 20);

    // T5: random wrap traffic
    base = drained;
    for (int n = 0; n < 10; n++) begin
      rand_store(32'h300 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3)), $urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    mem_ack = 1'b1;
    wait_empty("t5_drain_timeout", 30);
    check("t5_drained_total", 64'(drained - base), 64'(10));
    check("t5_model_empty", 64'(model_q.size()), 64'(0));

    // T6: reset while busy
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) raw_store(32'h700 + 32'(i * 4), 32'hE0 + 32'(i));
    st_valid = 1'b0;
    ld_addr  = 32'h700;
    @(posedge clk); #1;
    check("t6_busy_before", 64'(mem_req), 64'(1));
    check("t6_count_before", 64'(count), 64'(3));
    reset = 1'b1;
    #1;
    check("t6_req_async", 64'(mem_req), 64'(0));
    check("t6_count", 64'(count), 64'(0));
    check("t6_empty", 64'(empty), 64'(1));
    check("t6_ld_hit", 64'(ld_hit), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    base    = drained;
    mem_ack = 1'b1;
    raw_store(32'h800, 32'hD00D);
    st_valid = 1'b0;
    wait_empty("t6_post_drain_timeout", 10);
    check("t6_post_drained", 64'(drained - base), 64'(1));

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
